// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronizer, optional glitch filter, step/dir/position outputs.
// Define QUAD_DEC_FILTER_EN to insert the FILTER_LEN-cycle glitch filter ahead of the decoder.
module quad_decoder #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         en,
    input  logic         clr,
    output logic         step,
    output logic         dir,
    output logic [N-1:0] position,
    output logic         err
);

    generate
        if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_params
            $error("quad_decoder: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
        end
    endgenerate

    typedef enum logic {INIT, RUN} state_t;

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [1:0]             pair;
    logic [1:0]             cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
        end
    end

    assign pair = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

`ifdef QUAD_DEC_FILTER_EN
    localparam int INIT_LEN = SYNC_STAGES + FILTER_LEN;
    localparam int FCW      = $clog2(FILTER_LEN + 1);

    logic [FCW-1:0] stable_cnt;
    logic [1:0]     cand;
    logic [1:0]     filt;
    int unsigned    stable_nxt;

    // stable_nxt counts consecutive cycles the synchronized pair has matched cand
    always_comb begin
        stable_nxt = (pair == cand) ? int'(stable_cnt) + 1 : 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt <= '0;
            cand       <= '0;
            filt       <= '0;
        end else if (pair == filt) begin
            stable_cnt <= '0;
        end else begin
            cand <= pair;
            if (stable_nxt == FILTER_LEN) begin
                filt       <= pair;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= FCW'(stable_nxt);
            end
        end
    end

    assign cur = filt;
`else
    localparam int INIT_LEN = SYNC_STAGES;

    assign cur = pair;
`endif

    localparam int ICW = $clog2(INIT_LEN + 1);

    state_t         state, state_n;
    logic [ICW-1:0] init_cnt, init_cnt_n;
    logic [1:0]     prev, prev_n;
    logic           step_n, err_n, dir_n;
    logic [N-1:0]   position_n;
    logic [1:0]     delta;

    // Position along the forward cycle 00,10,11,01 (Gray-to-binary of {b,a})
    function automatic logic [1:0] phase_idx(input logic [1:0] ab);
        return {ab[0], ab[0] ^ ab[1]};
    endfunction

    assign delta = phase_idx(cur) - phase_idx(prev);

    always_comb begin
        state_n    = state;
        init_cnt_n = init_cnt;
        prev_n     = cur;
        step_n     = 1'b0;
        err_n      = 1'b0;
        dir_n      = dir;
        position_n = position;
        case (state)
            INIT: begin
                if (init_cnt == ICW'(INIT_LEN)) state_n = RUN;
                else                            init_cnt_n = init_cnt + ICW'(1);
            end
            RUN: begin
                if (en) begin
                    case (delta)
                        2'd1: begin
                            step_n     = 1'b1;
                            dir_n      = 1'b1;
                            position_n = position + N'(1);
                        end
                        2'd3: begin
                            step_n     = 1'b1;
                            dir_n      = 1'b0;
                            position_n = position - N'(1);
                        end
                        2'd2:    err_n = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_n = INIT;
        endcase
        if (clr) position_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            prev     <= '0;
            step     <= 1'b0;
            err      <= 1'b0;
            dir      <= 1'b0;
            position <= '0;
        end else begin
            state    <= state_n;
            init_cnt <= init_cnt_n;
            prev     <= prev_n;
            step     <= step_n;
            err      <= err_n;
            dir      <= dir_n;
            position <= position_n;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: vector table, hand-written corner sequences, random walk vs reference model.
module tb_quad_decoder;

    localparam int SYNC = 2;
    localparam int FLEN = 3;
`ifdef QUAD_DEC_FILTER_EN
    localparam int FILT_LAT = FLEN;
`else
    localparam int FILT_LAT = 0;
`endif
    localparam int LAT = SYNC + 1 + FILT_LAT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_in = 1'b1;
    logic       b_in = 1'b1;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic       step, dir, err;
    logic [7:0] position;

    quad_decoder #(.N(8), .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .en(en), .clr(clr),
        .step(step), .dir(dir), .position(position), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int obs_steps, obs_errs, cyc = 0;

    // Reference model: pins seen through a SYNC-deep delay line (plus a stability window)
    logic [1:0] m_sync[$];
    logic [1:0] m_win[$];
    logic [1:0] m_filt, m_prev;
    int         m_init;
    logic       m_step, m_err, m_dir;
    logic [7:0] m_pos;

    task automatic model_edge();
        logic [1:0] c, pin;
        logic       all_same;
        pin = {a_in, b_in};
        if (rst) begin
            m_sync.delete();
            repeat (SYNC) m_sync.push_back(2'b00);
            m_win.delete();
            m_filt = 2'b00; m_prev = 2'b00;
            m_init = SYNC + FILT_LAT + 1;
            m_step = 0; m_err = 0; m_dir = 0; m_pos = 0;
            return;
        end
        c = (FILT_LAT > 0) ? m_filt : m_sync[0];
        m_step = 0;
        m_err  = 0;
        if (m_init > 0) begin
            m_init--;
        end else if (en && c != m_prev) begin
            if (c[1] != m_prev[1] && c[0] != m_prev[0]) begin
                m_err = 1;
            end else begin
                m_step = 1;
                // A leads B: after an A change the phases differ, after a B change they agree
                m_dir  = (c[1] != m_prev[1]) ? (c[1] != c[0]) : (c[1] == c[0]);
                m_pos  = m_dir ? m_pos + 8'd1 : m_pos - 8'd1;
            end
        end
        m_prev = c;
        if (clr) m_pos = 0;
        m_win.push_back(m_sync[0]);
        if (m_win.size() > FLEN) void'(m_win.pop_front());
        if (m_win.size() == FLEN) begin
            all_same = 1;
            foreach (m_win[i]) if (m_win[i] != m_win[0]) all_same = 0;
            if (all_same) m_filt = m_win[0];
        end
        m_sync.push_back(pin);
        void'(m_sync.pop_front());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if ({step, err, dir, position} !== {m_step, m_err, m_dir, m_pos}) begin
            errors++;
            $display("FAIL model cycle %0d: step/err/dir/pos got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     cyc, step, err, dir, position, m_step, m_err, m_dir, m_pos);
        end
        obs_steps += int'(step);
        obs_errs  += int'(err);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    typedef struct {
        logic [1:0] ab;
        logic       en;
        logic       clr;
        int         hold;
        int         pos;
        int         steps;
        int         errs;
        int         dir;
    } vec_t;

    vec_t tbl[27];

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            {a_in, b_in} = tbl[i].ab;
            en  = tbl[i].en;
            clr = tbl[i].clr;
            obs_steps = 0;
            obs_errs  = 0;
            repeat (tbl[i].hold) tick();
            chk($sformatf("row%0d pos", i), int'(position), tbl[i].pos);
            chk($sformatf("row%0d steps", i), obs_steps, tbl[i].steps);
            chk($sformatf("row%0d errs", i), obs_errs, tbl[i].errs);
            chk($sformatf("row%0d dir", i), int'(dir), tbl[i].dir);
        end
        clr = 0;
    endtask

    logic [1:0] seq [4];
    int         ph;

    initial begin
        //            ab    en  clr hold pos steps errs dir
        tbl[0]  = '{2'b11, 1, 0, 14, 0,   0, 0, 0};
        tbl[1]  = '{2'b01, 1, 0, 10, 1,   1, 0, 1};
        tbl[2]  = '{2'b00, 1, 0, 10, 2,   1, 0, 1};
        tbl[3]  = '{2'b10, 1, 0, 10, 3,   1, 0, 1};
        tbl[4]  = '{2'b11, 1, 0, 10, 4,   1, 0, 1};
        tbl[5]  = '{2'b01, 1, 0, 10, 5,   1, 0, 1};
        tbl[6]  = '{2'b00, 1, 0, 10, 6,   1, 0, 1};
        tbl[7]  = '{2'b00, 1, 1, 1,  0,   0, 0, 1};
        tbl[8]  = '{2'b00, 1, 0, 5,  0,   0, 0, 1};
        tbl[9]  = '{2'b01, 1, 0, 10, 255, 1, 0, 0};
        tbl[10] = '{2'b00, 1, 0, 10, 0,   1, 0, 1};
        tbl[11] = '{2'b11, 1, 0, 10, 0,   0, 1, 1};
        tbl[12] = '{2'b01, 1, 0, 10, 1,   1, 0, 1};
        tbl[13] = '{2'b00, 1, 0, 10, 2,   1, 0, 1};
        tbl[14] = '{2'b10, 1, 0, 10, 3,   1, 0, 1};
        tbl[15] = '{2'b11, 1, 0, 10, 4,   1, 0, 1};
        tbl[16] = '{2'b01, 1, 0, 10, 5,   1, 0, 1};
        tbl[17] = '{2'b10, 1, 0, 10, 1,   1, 0, 1};
        tbl[18] = '{2'b11, 1, 0, 10, 2,   1, 0, 1};
        tbl[19] = '{2'b01, 1, 0, 10, 3,   1, 0, 1};
        tbl[20] = '{2'b00, 1, 0, 10, 4,   1, 0, 1};
        tbl[21] = '{2'b10, 1, 0, 10, 5,   1, 0, 1};
        tbl[22] = '{2'b11, 1, 0, 10, 6,   1, 0, 1};
        tbl[23] = '{2'b01, 1, 0, 10, 7,   1, 0, 1};
        tbl[24] = '{2'b00, 0, 0, 10, 7,   0, 0, 1};
        tbl[25] = '{2'b10, 0, 0, 10, 7,   0, 0, 1};
        tbl[26] = '{2'b11, 1, 0, 10, 8,   1, 0, 1};
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};

        // reset with pins at 11
        rst = 1;
        repeat (3) tick();
        chk("reset pos", int'(position), 0);
        chk("reset dir", int'(dir), 0);
        rst = 0;
        apply_rows(0, 16);

        // clear collides with a forward step (01 -> 00 at position 5)
        {a_in, b_in} = 2'b00;
        repeat (LAT - 1) tick();
        clr = 1;
        tick();
        chk("clr+step step", int'(step), 1);
        chk("clr+step dir", int'(dir), 1);
        chk("clr+step pos", int'(position), 0);
        clr = 0;
        repeat (10) tick();
        apply_rows(17, 26);

        // two-cycle pulse on a_in from 11
        obs_steps = 0;
        obs_errs  = 0;
        a_in = 0;
        repeat (2) tick();
        a_in = 1;
        repeat (12) tick();
        chk("pulse pos", int'(position), 8);
        chk("pulse steps", obs_steps, (FILT_LAT > 0) ? 0 : 2);
        chk("pulse errs", obs_errs, 0);

        // reset lands on the edge where a step would register
        {a_in, b_in} = 2'b01;
        repeat (LAT - 1) tick();
        rst = 1;
        tick();
        chk("midrst step", int'(step), 0);
        chk("midrst err", int'(err), 0);
        chk("midrst dir", int'(dir), 0);
        chk("midrst pos", int'(position), 0);
        rst = 0;
        obs_steps = 0;
        obs_errs  = 0;
        repeat (15) tick();
        chk("post-rst steps", obs_steps, 0);
        chk("post-rst errs", obs_errs, 0);

        // random walk from pins 01
        ph = 3;
        for (int i = 0; i < 400; i++) begin
            int unsigned mv;
            mv = $urandom_range(0, 9);
            if (mv < 4)       ph = (ph + 1) % 4;
            else if (mv < 8)  ph = (ph + 3) % 4;
            else if (mv == 8) ph = (ph + 2) % 4;
            {a_in, b_in} = seq[ph];
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            repeat ($urandom_range(1, 4)) tick();
        end
        clr = 0;
        en  = 1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
